text_tile_renderer: RTL and testbench

//  Parametrised text-mode pixel pipeline for the video path. Maps each screen

---
 rtl/text_tile_renderer.sv | 210 +++++++++++++++++++++
 tb/tb_text_tile_renderer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : text_tile_renderer
// Purpose  : Text-mode pixel pipeline. Maps screen pixel (x,y) to a character
//            cell of an internal text buffer, fetches the glyph row from an
//            external combinational font ROM and returns one pixel per clock
//            (latency 3, no stalls) with integer scaling, inverse video and
//            blink attributes.
// Ports    : clk, rst_n          - clock, async active-low reset
//            wr_en/wr_addr/wr_data - text buffer write {attr[1:0], char}
//                                  attr0 = inverse, attr1 = blink
//            pix_valid/pix_x/pix_y - pixel request
//            frame_start         - one pulse per frame, drives blink timer
//            font_char/font_row  - font ROM address (combinational, stage 1)
//            font_data           - font ROM row, MSB = leftmost pixel
//            pix_on/pix_valid_o  - rendered pixel and its qualifier
//            blink_phase         - current blink phase
// Revision : 1.0 - initial release
// ============================================================================
module text_tile_renderer #(
    parameter int COLS         = 16,
    parameter int ROWS         = 4,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 8,
    parameter int CHAR_BITS    = 7,
    parameter int SCALE_LOG2   = 1,
    parameter int X_BITS       = 10,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(COLS*ROWS)-1:0] wr_addr,
    input  logic [CHAR_BITS+1:0]         wr_data,
    input  logic                         pix_valid,
    input  logic [X_BITS-1:0]            pix_x,
    input  logic [X_BITS-1:0]            pix_y,
    input  logic                         frame_start,
    output logic [CHAR_BITS-1:0]         font_char,
    output logic [$clog2(GLYPH_H)-1:0]   font_row,
    input  logic [GLYPH_W-1:0]           font_data,
    output logic                         pix_on,
    output logic                         pix_valid_o,
    output logic                         blink_phase
);

    localparam int c_cells   = COLS * ROWS;
    localparam int c_aw      = $clog2(c_cells);
    localparam int c_dw      = CHAR_BITS + 2;
    localparam int c_gw_log2 = $clog2(GLYPH_W);
    localparam int c_gh_log2 = $clog2(GLYPH_H);
    localparam int c_cw      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_gw_log2-1:0] c_gx_max     = c_gw_log2'(GLYPH_W - 1);
    localparam logic [c_cw-1:0]      c_blink_last = c_cw'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Text buffer
    // ------------------------------------------------------------------
    logic [c_dw-1:0] r_buf [c_cells];
    logic            w_wr_ok;

    // Only a non-power-of-two cell count leaves unused addresses to reject.
    generate
        if (c_cells < (1 << c_aw)) begin : g_addr_guard
            assign w_wr_ok = (wr_addr < c_aw'(c_cells));
        end else begin : g_addr_full
            assign w_wr_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_cells; i++) begin
                r_buf[i] <= '0;
            end
        end else if (wr_en && w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Coordinate decode (feeds stage 1)
    // ------------------------------------------------------------------
    logic [X_BITS-1:0]    w_gx_full;
    logic [X_BITS-1:0]    w_gy_full;
    logic [X_BITS-1:0]    w_col;
    logic [X_BITS-1:0]    w_row;
    logic                 w_oob;
    logic [c_aw-1:0]      w_idx;

    assign w_gx_full = pix_x >> SCALE_LOG2;
    assign w_gy_full = pix_y >> SCALE_LOG2;
    assign w_col     = w_gx_full >> c_gw_log2;
    assign w_row     = w_gy_full >> c_gh_log2;
    assign w_oob     = (w_col >= X_BITS'(COLS)) || (w_row >= X_BITS'(ROWS));
    // Out-of-bounds pixels read cell 0; their glyph data is discarded in S3.
    assign w_idx     = w_oob ? '0 : c_aw'(w_row * X_BITS'(COLS) + w_col);

    // ------------------------------------------------------------------
    // Stage 1: cell address, font ROM address driven from here
    // ------------------------------------------------------------------
    logic                 r_s1_valid;
    logic                 r_s1_oob;
    logic [c_aw-1:0]      r_s1_idx;
    logic [c_gw_log2-1:0] r_s1_gx;
    logic [c_gh_log2-1:0] r_s1_gy;
    logic [c_dw-1:0]      w_cell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_gx    <= '0;
            r_s1_gy    <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_oob   <= w_oob;
            r_s1_idx   <= w_idx;
            r_s1_gx    <= w_gx_full[c_gw_log2-1:0];
            r_s1_gy    <= w_gy_full[c_gh_log2-1:0];
        end
    end

    // Asynchronous read: a write landing at the end of this cycle is not seen.
    assign w_cell    = r_buf[r_s1_idx];
    assign font_char = w_cell[CHAR_BITS-1:0];
    assign font_row  = r_s1_gy;

    // ------------------------------------------------------------------
    // Stage 2: glyph row and attributes
    // ------------------------------------------------------------------
    logic                 r_s2_valid;
    logic                 r_s2_oob;
    logic [GLYPH_W-1:0]   r_s2_data;
    logic [c_gw_log2-1:0] r_s2_gx;
    logic [1:0]           r_s2_attr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_oob   <= 1'b0;
            r_s2_data  <= '0;
            r_s2_gx    <= '0;
            r_s2_attr  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_oob   <= r_s1_oob;
            r_s2_data  <= font_data;
            r_s2_gx    <= r_s1_gx;
            r_s2_attr  <= w_cell[c_dw-1 -: 2];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: pixel select, blink mask, then inverse, then bounds/valid
    // ------------------------------------------------------------------
    logic w_bit;
    logic r_pix_on;
    logic r_pix_valid;
    logic r_blink_phase;
    logic [c_cw-1:0] r_frame_cnt;

    always_comb begin
        w_bit = r_s2_data[c_gx_max - r_s2_gx];
        if (r_s2_attr[1] && r_blink_phase) begin
            w_bit = 1'b0;
        end
        if (r_s2_attr[0]) begin
            w_bit = ~w_bit;
        end
        if (r_s2_oob || !r_s2_valid) begin
            w_bit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_on    <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_on    <= w_bit;
            r_pix_valid <= r_s2_valid;
        end
    end

    // ------------------------------------------------------------------
    // Blink timer: phase toggles every BLINK_FRAMES frame_start pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_frame_cnt == c_blink_last) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign pix_on      = r_pix_on;
    assign pix_valid_o = r_pix_valid;
    assign blink_phase = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_text_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_tile_renderer
// Purpose  : Directed self-checking bench for text_tile_renderer with a small
//            font ROM model ('A', 'B', everything else blank).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_tile_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [8:0] wr_data = '0;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       frame_start = 1'b0;
    logic [6:0] font_char;
    logic [2:0] font_row;
    logic [7:0] font_data;
    logic       pix_on;
    logic       pix_valid_o;
    logic       blink_phase;

    always #5 clk = ~clk;

    text_tile_renderer #(
        .COLS(16), .ROWS(4), .GLYPH_W(8), .GLYPH_H(8), .CHAR_BITS(7),
        .SCALE_LOG2(1), .X_BITS(10), .BLINK_FRAMES(32)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start),
        .font_char(font_char), .font_row(font_row), .font_data(font_data),
        .pix_on(pix_on), .pix_valid_o(pix_valid_o), .blink_phase(blink_phase)
    );

    function automatic logic [7:0] font_rom(input logic [6:0] c, input logic [2:0] r);
        case (c)
            7'h41:   return (r == 3'd0) ? 8'h18 : (r == 3'd1) ? 8'h24 : 8'h42;
            7'h42:   return (r == 3'd0) ? 8'h7C : 8'h42;
            default: return 8'h00;
        endcase
    endfunction

    always_comb font_data = font_rom(font_char, font_row);

    int    checks = 0;
    int    errors = 0;
    // Expectation pipe: entry pushed with the request, checked 3 cycles later.
    logic  e_chk [3];
    logic  e_on  [3];
    logic  e_vld [3];
    string e_tag [3];
    logic  nw_en = 1'b0;
    int    nw_addr = 0;
    int    nw_data = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic queue_write(input int a, input int d);
        nw_en   = 1'b1;
        nw_addr = a;
        nw_data = d;
    endtask

    task automatic tick(input string tag, input logic v, input int x, input int y,
                        input logic eon, input logic chk);
        @(negedge clk);
        if (e_chk[2]) begin
            check1({e_tag[2], ".on"},  pix_on,      e_on[2]);
            check1({e_tag[2], ".vld"}, pix_valid_o, e_vld[2]);
        end
        for (int i = 2; i > 0; i--) begin
            e_chk[i] = e_chk[i-1];
            e_on[i]  = e_on[i-1];
            e_vld[i] = e_vld[i-1];
            e_tag[i] = e_tag[i-1];
        end
        e_chk[0]  = chk;
        e_on[0]   = eon;
        e_vld[0]  = v;
        e_tag[0]  = tag;
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        wr_en     = nw_en;
        wr_addr   = 6'(nw_addr);
        wr_data   = 9'(nw_data);
        nw_en     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick("idle", 1'b0, 0, 0, 1'b0, 1'b1);
        end
    endtask

    task automatic sweep(input string tag, input int x0, input int y, input logic [15:0] pat);
        for (int i = 0; i < 16; i++) begin
            tick(tag, 1'b1, x0 + i, y, pat[15-i], 1'b1);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            e_chk[i] = 1'b0;
            e_on[i]  = 1'b0;
            e_vld[i] = 1'b0;
            e_tag[i] = "";
        end

        // Reset with requests present
        rst_n = 1'b0; pix_valid = 1'b1; pix_x = 10'd6; pix_y = 10'd0;
        repeat (3) @(negedge clk);
        check1("rst.on",    pix_on,      1'b0);
        check1("rst.vld",   pix_valid_o, 1'b0);
        check1("rst.blink", blink_phase, 1'b0);
        rst_n = 1'b1; pix_valid = 1'b0;

        // Empty buffer renders nothing
        tick("empty.a", 1'b1, 0,   0,  1'b0, 1'b1);
        tick("empty.b", 1'b1, 20,  6,  1'b0, 1'b1);
        tick("empty.c", 1'b1, 255, 63, 1'b0, 1'b1);
        idle(3);

        // Latency and bit order: 'A' row 0 = 0x18, row 1 = 0x24
        queue_write(0, 'h041); idle(1);
        sweep("a.row0", 0, 0, 16'h03C0);
        sweep("a.row1", 0, 2, 16'h0C30);

        // Attributes: cell1 inverse, cell2 blink, cell3 blink+inverse
        queue_write(1, 'h0C1); idle(1);
        queue_write(2, 'h141); idle(1);
        queue_write(3, 'h1C1); idle(1);
        sweep("inv",    16, 0, 16'hFC3F);
        sweep("blink0", 32, 0, 16'h03C0);
        sweep("binv0",  48, 0, 16'hFC3F);
        idle(3);

        frames(31);
        check1("blink.31", blink_phase, 1'b0);
        frames(1);
        check1("blink.32", blink_phase, 1'b1);
        sweep("blink1", 32, 0, 16'h0000);
        sweep("binv1",  48, 0, 16'hFFFF);
        sweep("plain1", 0,  0, 16'h03C0);
        idle(3);
        frames(32);
        check1("blink.64", blink_phase, 1'b0);
        sweep("blink2", 32, 0, 16'h03C0);
        idle(3);

        // Bounds: inverse blank cells at 0 and 63 light up unless out of range
        queue_write(0,  'h080); idle(1);
        queue_write(63, 'h080); idle(1);
        tick("bnd.in0",  1'b1, 0,    0,    1'b1, 1'b1);
        tick("bnd.in63", 1'b1, 255,  63,   1'b1, 1'b1);
        tick("bnd.x256", 1'b1, 256,  0,    1'b0, 1'b1);
        tick("bnd.y64",  1'b1, 0,    64,   1'b0, 1'b1);
        tick("bnd.both", 1'b1, 256,  64,   1'b0, 1'b1);
        tick("bnd.max",  1'b1, 1023, 1023, 1'b0, 1'b1);
        idle(3);

        // Write/read collision: 'A' gx1 = 0, 'B' (0x7C) gx1 = 1
        queue_write(0, 'h041); idle(1);
        tick("col.old", 1'b1, 2, 0, 1'b0, 1'b1);
        queue_write(0, 'h042);
        tick("col.new", 1'b1, 2, 0, 1'b1, 1'b1);
        // Bubbles
        tick("bub.v1", 1'b1, 2, 0, 1'b1, 1'b1);
        tick("bub.v0", 1'b0, 2, 0, 1'b0, 1'b1);
        tick("bub.v2", 1'b1, 2, 0, 1'b1, 1'b1);
        tick("bub.v3", 1'b0, 2, 0, 1'b0, 1'b1);
        idle(3);

        // Mid-stream reset with pixels in flight
        tick("mrst.p0", 1'b1, 2, 0, 1'b1, 1'b0);
        tick("mrst.p1", 1'b1, 2, 0, 1'b1, 1'b0);
        tick("mrst.p2", 1'b1, 2, 0, 1'b1, 1'b0);
        @(negedge clk);
        check1("mrst.pre.vld", pix_valid_o, 1'b1);
        check1("mrst.pre.on",  pix_on,      1'b1);
        rst_n = 1'b0; pix_valid = 1'b0;
        #1;
        check1("mrst.now.vld", pix_valid_o, 1'b0);
        check1("mrst.now.on",  pix_on,      1'b0);
        for (int i = 0; i < 3; i++) e_chk[i] = 1'b0;
        @(negedge clk);
        check1("mrst.hold.vld", pix_valid_o, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("mrst.flush.vld", pix_valid_o, 1'b0);
        end
        tick("mrst.clr0", 1'b1, 2, 0, 1'b0, 1'b1);
        tick("mrst.clr1", 1'b1, 6, 0, 1'b0, 1'b1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
